// File: rtl/seq_shift_pkg.sv
// Shared definitions for the sequential MIPS shift/rotate unit.
// Optional feature macro: SEQ_SHIFT_FAST_EN (adds a four-bit step).
package seq_shift_pkg;

  // Operation encodings on the op port
  localparam logic [1:0] LO_L = 2'd0;  // logical left
  localparam logic [1:0] LO_R = 2'd1;  // logical right
  localparam logic [1:0] AL_R = 2'd2;  // arithmetic right
  localparam logic [1:0] CI_L = 2'd3;  // rotate left

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam int unsigned FAST_STEP = 4;

endpackage

// File: rtl/shift_step.sv
// Combinational single step of the shift/rotate datapath.
// With SEQ_SHIFT_FAST_EN defined, four_bit selects a four-position step;
// otherwise only the one-position step exists and four_bit is ignored.
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [1:0]            op,
  input  logic                  four_bit,
  output logic [DATA_WIDTH-1:0] acc_next
);

  logic [DATA_WIDTH-1:0] step1;

  // One-position step for each operation
  always_comb begin
    step1 = acc;
    unique case (op)
      LO_L: step1 = {acc[DATA_WIDTH-2:0], 1'b0};
      LO_R: step1 = {1'b0, acc[DATA_WIDTH-1:1]};
      AL_R: step1 = {acc[DATA_WIDTH-1], acc[DATA_WIDTH-1:1]};
      CI_L: step1 = {acc[DATA_WIDTH-2:0], acc[DATA_WIDTH-1]};
      default: step1 = acc;
    endcase
  end

`ifdef SEQ_SHIFT_FAST_EN
  logic [DATA_WIDTH-1:0] step4;

  // Four-position step: same as four one-position steps
  always_comb begin
    step4 = acc;
    unique case (op)
      LO_L: step4 = {acc[DATA_WIDTH-5:0], 4'b0000};
      LO_R: step4 = {4'b0000, acc[DATA_WIDTH-1:4]};
      AL_R: step4 = {{4{acc[DATA_WIDTH-1]}}, acc[DATA_WIDTH-1:4]};
      CI_L: step4 = {acc[DATA_WIDTH-5:0], acc[DATA_WIDTH-1:DATA_WIDTH-4]};
      default: step4 = acc;
    endcase
  end

  // Pick the step width requested by the controller
  always_comb begin
    acc_next = four_bit ? step4 : step1;
  end
`else
  logic unused_four_bit;
  assign unused_four_bit = four_bit;

  // Only the one-position step is built
  always_comb begin
    acc_next = step1;
  end
`endif

endmodule

// File: rtl/seq_shift_mips.sv
// Iterative shift/rotate unit with start/busy/done handshake.
// Processes one bit per cycle, or four bits per cycle while at least four
// remain when SEQ_SHIFT_FAST_EN is defined.
module seq_shift_mips
  import seq_shift_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] shift_count,
  input  logic [1:0]            op,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_out
);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [ADDR_WIDTH-1:0] rem_q;
  logic [1:0]            op_q;

  logic                  four_bit;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] rem_next;
  logic [DATA_WIDTH-1:0] acc_next;

  // Choose the step size for the current cycle and the resulting remainder
  always_comb begin
`ifdef SEQ_SHIFT_FAST_EN
    four_bit = (rem_q >= ADDR_WIDTH'(FAST_STEP));
`else
    four_bit = 1'b0;
`endif
    step     = four_bit ? ADDR_WIDTH'(FAST_STEP) : ADDR_WIDTH'(1);
    rem_next = rem_q - step;
  end

  shift_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift_step (
    .acc      (acc_q),
    .op       (op_q),
    .four_bit (four_bit),
    .acc_next (acc_next)
  );

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      op_q     <= LO_L;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_q <= data_in;
            rem_q <= shift_count;
            op_q  <= op;
            if (shift_count == '0) begin
              // Zero count completes without entering SHIFT
              data_out <= data_in;
              done     <= 1'b1;
            end else begin
              busy    <= 1'b1;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc_q <= acc_next;
          rem_q <= rem_next;
          if (rem_next == '0) begin
            data_out <= acc_next;
            done     <= 1'b1;
            busy     <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_mips.sv
// Directed self-checking bench for seq_shift_mips.
// Expected latencies follow SEQ_SHIFT_FAST_EN when it is defined.
module tb_seq_shift_mips;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shift_count;
  logic [1:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] data_out;

  int n_checks;
  int n_errors;

  seq_shift_mips #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .shift_count (shift_count),
    .op          (op),
    .busy        (busy),
    .done        (done),
    .data_out    (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int n);
`ifdef SEQ_SHIFT_FAST_EN
    return n / 4 + n % 4;
`else
    return n;
`endif
  endfunction

  // Issue one operation and check result, latency and handshake behaviour
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                        input logic [4:0] c, input logic [31:0] exp);
    int n;
    logic busy_ok;
    busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; op = o; data_in = d; shift_count = c;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat(int'(c))));
    check({tag, "_data"}, data_out, exp);
    check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    check({tag, "_busy_during"}, {31'b0, busy_ok}, 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int n;
    int done_cnt;
    logic [31:0] res;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; start = 1'b0; data_in = '0; shift_count = '0; op = 2'd0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_data", data_out, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("sll31", 2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000);
    run_op("sra4",  2'd2, 32'hF000_0000, 5'd4,  32'hFF00_0000);
    run_op("srl4",  2'd1, 32'hF000_0000, 5'd4,  32'h0F00_0000);
    run_op("rol1",  2'd3, 32'h8000_0001, 5'd1,  32'h0000_0003);
    run_op("rol5",  2'd3, 32'h8000_0001, 5'd5,  32'h0000_0030);
    run_op("rol31", 2'd3, 32'h1234_5678, 5'd31, 32'h091A_2B3C);
    run_op("sra7",  2'd2, 32'h8000_00F0, 5'd7,  32'hFF00_0001);
    run_op("cnt0",  2'd1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);

    // start while busy must be ignored
    @(negedge clk);
    start = 1'b1; op = 2'd0; data_in = 32'h0000_0001; shift_count = 5'd20;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'd1; data_in = 32'hFFFF_FFFF; shift_count = 5'd1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    res = '0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        done_cnt++;
        res = data_out;
      end
      @(negedge clk);
    end
    check("ign_done_cnt", 32'(done_cnt), 32'd1);
    check("ign_data", res, 32'h0010_0000);

    // start held high: accepted again in the done cycle
    @(negedge clk);
    start = 1'b1; op = 2'd1; data_in = 32'h0000_0080; shift_count = 5'd2;
    @(negedge clk);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("held1_lat", 32'(n), 32'(exp_lat(2)));
    check("held1_data", data_out, 32'h0000_0020);
    op = 2'd0; data_in = 32'h0000_0001; shift_count = 5'd3;
    @(negedge clk);
    start = 1'b0;
    check("held2_busy", {31'b0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("held2_lat", 32'(n), 32'(exp_lat(3)));
    check("held2_data", data_out, 32'h0000_0008);

    // reset mid-operation aborts with no done
    @(negedge clk);
    start = 1'b1; op = 2'd0; data_in = 32'h0000_0001; shift_count = 5'd20;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_data", data_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check("abort_quiet", 32'(done_cnt), 32'd0);
    run_op("post_rst", 2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
